// File: rtl/button_ram_writer.sv
// Button synchronizer/debouncer that records the button byte into RAM via a
// byte-serial address/write sequence. Define BTN_DEBOUNCE_EN to enable the debouncer.
module button_ram_writer #(
    parameter logic [15:0] BTN_ADDRESS     = 16'h0010,
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] btn_in,
    input  logic       refresh,
    output logic       wr_en,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       busy,
    output logic [7:0] write_count
);

    typedef enum logic [1:0] {IDLE, ADDR_HI, ADDR_LO, WRITE} state_t;

    state_t     state;
    logic [7:0] sync_p0;
    logic [7:0] sync_p1;
    logic [7:0] stable;
    logic       stable_load;
    logic       pending;

    // Stage p0/p1: two-flop synchronizer per button bit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_p0 <= 8'h00;
            sync_p1 <= 8'h00;
        end else begin
            sync_p0 <= btn_in;
            sync_p1 <= sync_p0;
        end
    end

`ifdef BTN_DEBOUNCE_EN
    // The current cycle plus the counted history make up the required run of equal samples.
    localparam logic [15:0] STABLE_THRESH = DEBOUNCE_CYCLES - 16'd2;

    logic [7:0]  sync_prev;
    logic [15:0] stable_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_prev  <= 8'h00;
            stable_cnt <= 16'd0;
        end else begin
            sync_prev <= sync_p1;
            if (sync_p1 != sync_prev) begin
                stable_cnt <= 16'd0;
            end else if (stable_cnt != 16'hFFFF) begin
                stable_cnt <= stable_cnt + 16'd1;
            end
        end
    end

    assign stable_load = (sync_p1 == sync_prev) && (stable_cnt >= STABLE_THRESH) &&
                         (sync_p1 != stable);
`else
    logic unused_debounce_cfg;
    assign unused_debounce_cfg = ^DEBOUNCE_CYCLES;
    assign stable_load         = (sync_p1 != stable);
`endif

    // Stage p2: accepted button state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stable <= 8'h00;
        end else if (stable_load) begin
            stable <= sync_p1;
        end
    end

    // A new request wins over the clear at IDLE exit so it is never lost.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            pending     <= 1'b0;
            wr_en       <= 1'b0;
            wr_addr     <= 8'h00;
            wr_data     <= 8'h00;
            busy        <= 1'b0;
            write_count <= 8'h00;
        end else begin
            if (stable_load || refresh) begin
                pending <= 1'b1;
            end else if (state == IDLE && pending) begin
                pending <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (pending) begin
                        state   <= ADDR_HI;
                        wr_data <= stable;
                        wr_addr <= BTN_ADDRESS[15:8];
                        busy    <= 1'b1;
                    end
                end
                ADDR_HI: begin
                    state   <= ADDR_LO;
                    wr_addr <= BTN_ADDRESS[7:0];
                end
                ADDR_LO: begin
                    state   <= WRITE;
                    wr_addr <= 8'h00;
                    wr_en   <= 1'b1;
                end
                WRITE: begin
                    state       <= IDLE;
                    wr_en       <= 1'b0;
                    busy        <= 1'b0;
                    write_count <= write_count + 8'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_button_ram_writer.sv
// Bench for button_ram_writer: vector table, directed corner sequences and a
// randomized run scored against a sample-history reference model.
module tb_button_ram_writer;

    localparam logic [15:0] ADDR = 16'h0010;
    localparam int          D    = 4;
`ifdef BTN_DEBOUNCE_EN
    localparam int          LAT  = 2 + D;
    localparam logic [7:0]  BTN_A = 8'h05;
`else
    localparam int          LAT  = 3;
    localparam logic [7:0]  BTN_A = 8'h3C;
`endif

    logic       clk;
    logic       reset;
    logic [7:0] btn_in;
    logic       refresh;
    logic       wr_en;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       busy;
    logic [7:0] write_count;

    button_ram_writer #(.BTN_ADDRESS(ADDR), .DEBOUNCE_CYCLES(16'(D))) dut (
        .clk(clk), .reset(reset), .btn_in(btn_in), .refresh(refresh),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .write_count(write_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit sb_en    = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: samples per edge, a transaction phase counter and a pending flag.
    logic [7:0] hist[$];
    logic [7:0] m_stable, m_snap, m_cnt;
    bit         m_pend;
    int         m_phase;

    task automatic model_step(input logic [7:0] b, input logic rf);
        logic [7:0] new_stable;
        bit         set;
        bit         same;
        int         n;
        new_stable = m_stable;
        set = rf;
        hist.push_back(b);
        n = hist.size();
`ifdef BTN_DEBOUNCE_EN
        if (n >= D + 2) begin
            same = 1'b1;
            for (int k = n - D - 2; k <= n - 3; k++)
                if (hist[k] != hist[n-3]) same = 1'b0;
            if (same && hist[n-3] != m_stable) begin
                new_stable = hist[n-3];
                set = 1'b1;
            end
        end
`else
        same = 1'b0;
        if (n >= 3 && hist[n-3] != m_stable) begin
            new_stable = hist[n-3];
            set = 1'b1;
        end
`endif
        if (m_phase == 0) begin
            if (m_pend) begin
                m_snap  = m_stable;
                m_pend  = 1'b0;
                m_phase = 1;
            end
        end else if (m_phase == 3) begin
            m_phase = 0;
            m_cnt   = m_cnt + 8'd1;
        end else begin
            m_phase = m_phase + 1;
        end
        if (set) m_pend = 1'b1;
        m_stable = new_stable;
        if (hist.size() > 32) void'(hist.pop_front());
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            hist.delete();
            m_stable = 8'h00; m_snap = 8'h00; m_cnt = 8'h00;
            m_pend = 1'b0; m_phase = 0;
        end else begin
            model_step(btn_in, refresh);
        end
    end

    function automatic logic [25:0] model_vec();
        logic [7:0] a;
        a = (m_phase == 1) ? ADDR[15:8] : (m_phase == 2) ? ADDR[7:0] : 8'h00;
        return {m_phase == 3, a, m_snap, m_phase != 0, m_cnt};
    endfunction

    always @(negedge clk) begin
        if (sb_en) check("scoreboard", 32'({wr_en, wr_addr, wr_data, busy, write_count}),
                         32'(model_vec()));
    end

    typedef struct {
        logic [7:0] btn;
        logic       rf;
        logic       en;
        logic [7:0] addr;
        logic [7:0] data;
        logic       bsy;
        logic [7:0] cnt;
    } vec_t;
    vec_t tbl[15];

    function automatic vec_t mk(input logic rf, input logic en, input logic [7:0] addr,
                                input logic bsy, input logic [7:0] cnt);
        vec_t v;
        v.btn = 8'h00; v.rf = rf; v.en = en; v.addr = addr; v.data = 8'h00;
        v.bsy = bsy; v.cnt = cnt;
        return v;
    endfunction

    initial begin
        int         pulses;
        int         first_w;
        int         second_w;
        int         idle_between;
        bit         found;
        logic [7:0] wdata[$];

        // Single refresh, then a refresh landing while the first one is in flight.
        tbl[0]  = mk(1, 0, 8'h00, 0, 8'd0);
        tbl[1]  = mk(0, 0, 8'h00, 1, 8'd0);
        tbl[2]  = mk(0, 0, 8'h10, 1, 8'd0);
        tbl[3]  = mk(0, 1, 8'h00, 1, 8'd0);
        tbl[4]  = mk(0, 0, 8'h00, 0, 8'd1);
        tbl[5]  = mk(1, 0, 8'h00, 0, 8'd1);
        tbl[6]  = mk(1, 0, 8'h00, 1, 8'd1);
        tbl[7]  = mk(0, 0, 8'h10, 1, 8'd1);
        tbl[8]  = mk(0, 1, 8'h00, 1, 8'd1);
        tbl[9]  = mk(0, 0, 8'h00, 0, 8'd2);
        tbl[10] = mk(0, 0, 8'h00, 1, 8'd2);
        tbl[11] = mk(0, 0, 8'h10, 1, 8'd2);
        tbl[12] = mk(0, 1, 8'h00, 1, 8'd2);
        tbl[13] = mk(0, 0, 8'h00, 0, 8'd3);
        tbl[14] = mk(0, 0, 8'h00, 0, 8'd3);

        reset = 1'b1; btn_in = 8'h00; refresh = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        sb_en = 1'b1;

        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            check("idle_after_reset", 32'({wr_en, wr_addr, wr_data, busy, write_count}), 32'd0);
        end

        for (int i = 0; i < 15; i++) begin
            btn_in = tbl[i].btn; refresh = tbl[i].rf;
            @(negedge clk);
            check($sformatf("table[%0d]", i),
                  32'({wr_en, wr_addr, wr_data, busy, write_count}),
                  32'({tbl[i].en, tbl[i].addr, tbl[i].data, tbl[i].bsy, tbl[i].cnt}));
        end
        refresh = 1'b0;

        // Button change: three-cycle address/write sequence after the debounce latency.
        btn_in = BTN_A;
        for (int e = 1; e <= LAT + 4; e++) begin
            @(negedge clk);
            if (e <= LAT) check("change_wait_busy", 32'(busy), 32'd0);
            else if (e == LAT + 1) check("change_addr_hi", 32'({wr_en, wr_addr, busy}), 32'({1'b0, 8'h00, 1'b1}));
            else if (e == LAT + 2) check("change_addr_lo", 32'({wr_en, wr_addr, busy}), 32'({1'b0, 8'h10, 1'b1}));
            else if (e == LAT + 3) check("change_write", 32'({wr_en, wr_data}), 32'({1'b1, BTN_A}));
            else check("change_count", 32'({busy, write_count}), 32'({1'b0, 8'd4}));
        end

        // Bounce: toggle every two cycles, then settle at 00.
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            btn_in = ((i / 2) % 2 == 0) ? 8'h00 : BTN_A;
            @(negedge clk);
            if (wr_en) pulses++;
        end
        btn_in = 8'h00;
        wdata.delete();
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (wr_en) wdata.push_back(wr_data);
        end
`ifdef BTN_DEBOUNCE_EN
        check("bounce_no_write", 32'(pulses), 32'd0);
        check("settle_one_write", 32'(wdata.size()), 32'd1);
        if (wdata.size() > 0) check("settle_data", 32'(wdata[0]), 32'h00);
`endif

        // Change then refresh while busy: two back-to-back writes of the same value.
        btn_in = 8'h81;
        found = 1'b0;
        for (int i = 0; i < LAT + 10 && !found; i++) begin
            @(negedge clk);
            if (busy) found = 1'b1;
        end
        check("coalesce_start", 32'(found), 32'd1);
        refresh = 1'b1;
        @(negedge clk);
        refresh = 1'b0;
        wdata.delete();
        first_w = -1; second_w = -1; idle_between = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (wr_en) begin
                wdata.push_back(wr_data);
                if (first_w < 0) first_w = i; else if (second_w < 0) second_w = i;
            end
            if (!busy && first_w >= 0 && second_w < 0) idle_between++;
        end
        check("coalesce_pulses", 32'(wdata.size()), 32'd2);
        check("coalesce_spacing", 32'(second_w - first_w), 32'd4);
        check("coalesce_idle", 32'(idle_between), 32'd1);
        foreach (wdata[k]) check("coalesce_data", 32'(wdata[k]), 32'h81);

        // Reset in ADDR_LO abandons the transaction without a strobe.
        refresh = 1'b1;
        @(negedge clk);
        refresh = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("in_addr_lo", 32'({busy, wr_en, wr_addr}), 32'({1'b1, 1'b0, 8'h10}));
        #2;
        reset = 1'b1; btn_in = 8'h00;
        #1;
        check("reset_async", 32'({wr_en, wr_addr, wr_data, busy, write_count}), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (wr_en) pulses++;
        end
        check("no_write_after_reset", 32'(pulses), 32'd0);
        check("count_after_reset", 32'(write_count), 32'd0);

        // Write counter wrap.
        for (int i = 0; i < 256; i++) begin
            refresh = 1'b1;
            @(negedge clk);
            refresh = 1'b0;
            repeat (4) @(negedge clk);
            if (i == 254) check("count_255", 32'(write_count), 32'd255);
        end
        check("count_wrap", 32'(write_count), 32'd0);

        // Randomized run: held button values of random length, sparse refreshes.
        for (int i = 0; i < 300; i++) begin
            btn_in = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 3) == 0) btn_in = 8'h00;
            for (int j = 0; j < int'($urandom_range(1, 12)); j++) begin
                refresh = ($urandom_range(0, 15) == 0);
                @(negedge clk);
            end
        end
        refresh = 1'b0;
        repeat (20) @(negedge clk);
        sb_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
